// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Interlock and flush controller for the 5-stage interrupt-capable pipeline.
// Bypassing already covers most RAW hazards. This block handles the cases it
// cannot cover:
//   * a load in EX feeding the instruction in ID (load-use), and
//   * any producer whose result an ID-stage compare (branch, jr, mtc0) needs
//     before it can be forwarded.
// For these it freezes PC and IF/ID and inserts bubbles into ID/EX.
// It also sequences interrupt entry (flush, EPC capture, vector select,
// masking) and eret exit.
//
// Parameters
//   REG_W          register-specifier width
//   LOADCMP_STALL  bubbles for a load in EX feeding an ID-stage compare (1..3)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   IF_ID_Rs/Rt      source specifiers of the instruction in ID
//   IF_ID_UsesRt     ID instruction actually reads Rt
//   ID_Cmp           ID instruction resolves in ID (branch, jr, mtc0)
//   ID_Taken         branch/jump resolved taken in ID
//   ID_Eret          eret in ID
//   ID_EX_Rd         destination of the instruction in EX
//   ID_EX_RegWrite   instruction in EX writes Rd
//   ID_EX_MemRead    instruction in EX is a load
//   EX_MEM_Rd        destination of the instruction in MEM
//   EX_MEM_MemRead   instruction in MEM is a load
//   intr_req         level interrupt request
//   PCWrite          PC update enable
//   IF_ID_Write      IF/ID register enable
//   IF_ID_Flush      zero the IF/ID register
//   ID_EX_Flush      insert a bubble into ID/EX
//   EPC_Write        capture the ID-stage PC into EPC
//   PC_Intr          select the interrupt vector as next PC
//   intr_ack         one-cycle interrupt-acceptance pulse
//   intr_masked      interrupt service in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RUN   | hazards evaluated each cycle; a first bubble is issued here
// S_STALL | extra bubbles of a multi-cycle stall; cnt more cycles after this
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_W         = 6,
    parameter int LOADCMP_STALL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             ID_Cmp,
    input  logic             ID_Taken,
    input  logic             ID_Eret,
    input  logic [REG_W-1:0] ID_EX_Rd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] EX_MEM_Rd,
    input  logic             EX_MEM_MemRead,
    input  logic             intr_req,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EPC_Write,
    output logic             PC_Intr,
    output logic             intr_ack,
    output logic             intr_masked
);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } state_t;

    localparam logic [1:0] LC_N = 2'(LOADCMP_STALL);

    state_t     state;
    logic [1:0] cnt;
    logic       msk;

    // Register r0 is hardwired to zero, so it never creates a dependency.
    function automatic logic src_hit(
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        return (dst != '0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    logic       hit_ex;
    logic       hit_mem;
    logic [1:0] need;
    logic       run_free;
    logic       stall_now;
    logic       accept;
    logic       eret_exit;

    assign hit_ex  = src_hit(ID_EX_Rd,  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);
    assign hit_mem = src_hit(EX_MEM_Rd, IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt);

    // Bubbles required by the ID instruction; first matching rule wins.
    // Only meaningful in S_RUN: in S_STALL the ID operands are not re-judged.
    always_comb begin
        need = 2'd0;
        if (state == S_RUN) begin
            if (ID_EX_MemRead && hit_ex && ID_Cmp) begin
                need = LC_N;
            end else if (ID_EX_MemRead && hit_ex) begin
                need = 2'd1;
            end else if (ID_EX_RegWrite && hit_ex && ID_Cmp) begin
                need = 2'd1;
            end else if (EX_MEM_MemRead && hit_mem && ID_Cmp) begin
                need = 2'd1;
            end
        end
    end

    assign stall_now = (state == S_STALL) || (need != 2'd0);
    assign run_free  = (state == S_RUN) && (need == 2'd0);

    // A stall defers interrupt entry: the ID instruction must be able to
    // advance so that EPC names a clean restart point.
    assign accept    = run_free && intr_req && !msk;
    assign eret_exit = run_free && !accept && ID_Eret && msk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= 2'd0;
            msk   <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (need > 2'd1) begin
                        // First bubble is issued now; cnt counts the extra
                        // STALL cycles beyond the one entered next.
                        state <= S_STALL;
                        cnt   <= need - 2'd2;
                    end
                    if (accept) begin
                        msk <= 1'b1;
                    end else if (eret_exit) begin
                        msk <= 1'b0;
                    end
                end
                S_STALL: begin
                    if (cnt == 2'd0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: begin
                    state <= S_RUN;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    // Mealy outputs: a hazard bubbles the pipeline in the cycle it is seen.
    // Reset forces a frozen, fully flushed pipeline for as long as rst is high.
    always_comb begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EPC_Write   = 1'b0;
        PC_Intr     = 1'b0;
        intr_ack    = 1'b0;
        intr_masked = msk;
        if (rst) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            intr_masked = 1'b0;
        end else if (stall_now) begin
            ID_EX_Flush = 1'b1;
        end else begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
            if (accept) begin
                // Interrupt beats a taken branch; EPC then holds the branch PC.
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                EPC_Write   = 1'b1;
                PC_Intr     = 1'b1;
                intr_ack    = 1'b1;
            end else if (ID_Taken || ID_Eret) begin
                // eret outside service behaves as a plain taken jump.
                IF_ID_Flush = 1'b1;
            end
        end
    end

endmodule
